// File: rtl/fixedpoint_pkg.sv
// rtl/fixedpoint_pkg.sv - shared types and parameter checks for the fixed-point divider
//
// Purpose: FSM state encoding and a Q-format width legality helper.
// Ports:   none (package).

package fixedpoint_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // A Q(WII.WIF) format needs at least the sign bit as integer part.
  function automatic bit widths_legal(input int wii, input int wif);
    return (wii >= 1) && (wif >= 0);
  endfunction

endpackage

// File: rtl/seq_fixedpoint_div.sv
// rtl/seq_fixedpoint_div.sv - multi-cycle signed Q(WII.WIF) restoring divider with saturation
//
// Purpose: computes dividend / divisor one quotient bit per cycle, then rounds
//          (half away from zero) or truncates, applies the sign and saturates.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset, aborts any operation
//   in_valid   in   operands valid
//   in_ready   out  block idle and able to take operands
//   dividend   in   W-bit signed Q(WII.WIF)
//   divisor    in   W-bit signed Q(WII.WIF)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer takes the result
//   out        out  W-bit signed Q(WII.WIF) quotient (registered)
//   upflow     out  quotient saturated
//   downflow   out  nonzero true quotient collapsed to zero
//   div_zero   out  divisor was zero

module seq_fixedpoint_div
  import fixedpoint_pkg::*;
#(
  parameter int WII   = 16,
  parameter int WIF   = 16,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WII+WIF-1:0]   dividend,
  input  logic [WII+WIF-1:0]   divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WII+WIF-1:0]   out,
  output logic                 upflow,
  output logic                 downflow,
  output logic                 div_zero
);

  localparam int W  = WII + WIF;
  // Numerator is |dividend| << (WIF + ROUND); one quotient bit per numerator bit.
  localparam int N  = WII + 2 * WIF + ROUND;
  localparam int QB = W + WIF;
  // Rounded magnitude can carry one bit past the raw quotient.
  localparam int MW = QB + 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [MW-1:0] LIM_NEG = MW'(1) << (W - 1);
  localparam logic [MW-1:0] LIM_POS = LIM_NEG - MW'(1);
  localparam logic [W-1:0]  OUT_MAX = LIM_POS[W-1:0];
  localparam logic [W-1:0]  OUT_MIN = LIM_NEG[W-1:0];

  if (!widths_legal(WII, WIF)) begin : g_bad_widths
    $error("seq_fixedpoint_div: illegal WII/WIF");
  end

  div_state_t r_state;
  div_state_t w_next_state;

  logic [N-1:0]  r_num;       // numerator shifting out MSB-first, quotient shifting in
  logic [W-1:0]  r_rem;       // partial remainder, always < divisor magnitude
  logic [W-1:0]  r_dvs;       // divisor magnitude
  logic [CW-1:0] r_cnt;
  logic          r_sign;
  logic          r_dvd_nz;
  logic          r_dvd_neg;
  logic          r_dvs_zero;

  logic [W-1:0]  r_out;
  logic          r_upflow;
  logic          r_downflow;
  logic          r_div_zero;

  logic          w_accept;
  logic [W:0]    w_dvd_ext;
  logic [W:0]    w_dvs_ext;
  logic [W-1:0]  w_dvd_mag;
  logic [W-1:0]  w_dvs_mag;
  logic          w_dvs_is_zero;

  logic [W:0]    w_trial;
  logic          w_ge;
  logic [W-1:0]  w_rem_next;

  logic [QB-1:0] w_q_main;
  logic          w_half;
  logic [MW-1:0] w_mag;
  logic [MW-1:0] w_limit;
  logic [W-1:0]  w_mag_lo;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          // A zero divisor has nothing to iterate; its result is decided in FIX.
          w_next_state = w_dvs_is_zero ? FIX : CALC;
        end
      end
      CALC: begin
        if (r_cnt == CW'(1)) begin
          w_next_state = FIX;
        end
      end
      FIX: begin
        w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- operand capture
  assign w_accept      = in_valid && in_ready;
  // One bit wider so that the most negative value has an exact magnitude.
  assign w_dvd_ext     = {dividend[W-1], dividend};
  assign w_dvs_ext     = {divisor[W-1], divisor};
  assign w_dvd_mag     = W'(dividend[W-1] ? -w_dvd_ext : w_dvd_ext);
  assign w_dvs_mag     = W'(divisor[W-1] ? -w_dvs_ext : w_dvs_ext);
  assign w_dvs_is_zero = (divisor == '0);

  // ---------------------------------------------------------------- restoring step
  assign w_trial    = {r_rem, r_num[N-1]};
  assign w_ge       = (w_trial >= {1'b0, r_dvs});
  assign w_rem_next = w_ge ? W'(w_trial - {1'b0, r_dvs}) : w_trial[W-1:0];

  // ---------------------------------------------------------------- round / saturate
  // With ROUND=1 the last quotient bit is the half-bit; adding it to the
  // magnitude rounds half away from zero once the sign is reapplied.
  assign w_q_main = r_num[N-1:ROUND];
  assign w_half   = (ROUND != 0) && r_num[0];
  assign w_mag    = MW'(w_q_main) + MW'(w_half);
  assign w_limit  = r_sign ? LIM_NEG : LIM_POS;
  assign w_mag_lo = w_mag[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_dvd_nz   <= 1'b0;
      r_dvd_neg  <= 1'b0;
      r_dvs_zero <= 1'b0;
      r_out      <= '0;
      r_upflow   <= 1'b0;
      r_downflow <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_num      <= N'(w_dvd_mag) << (WIF + ROUND);
            r_rem      <= '0;
            r_dvs      <= w_dvs_mag;
            r_cnt      <= CW'(N);
            r_sign     <= dividend[W-1] ^ divisor[W-1];
            r_dvd_nz   <= (dividend != '0);
            r_dvd_neg  <= dividend[W-1];
            r_dvs_zero <= w_dvs_is_zero;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_num <= N'({r_num, w_ge});
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          if (r_dvs_zero) begin
            r_div_zero <= 1'b1;
            r_upflow   <= 1'b0;
            r_downflow <= 1'b0;
            if (!r_dvd_nz) begin
              r_out <= '0;
            end else begin
              r_out <= r_dvd_neg ? OUT_MIN : OUT_MAX;
            end
          end else begin
            r_div_zero <= 1'b0;
            if (w_mag > w_limit) begin
              r_out      <= r_sign ? OUT_MIN : OUT_MAX;
              r_upflow   <= 1'b1;
              r_downflow <= 1'b0;
            end else begin
              r_out      <= r_sign ? -w_mag_lo : w_mag_lo;
              r_upflow   <= 1'b0;
              r_downflow <= r_dvd_nz && (w_mag == '0);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out      = r_out;
  assign upflow   = r_upflow;
  assign downflow = r_downflow;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_fixedpoint_div.sv
// tb/tb_seq_fixedpoint_div.sv - directed self-checking bench for seq_fixedpoint_div

module tb_seq_fixedpoint_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        upflow;
  logic        downflow;
  logic        div_zero;

  int n_checks = 0;
  int n_errors = 0;

  localparam int LAT_NORM = 51;
  localparam int LAT_DZ   = 2;

  seq_fixedpoint_div #(.WII(16), .WIF(16), .ROUND(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .upflow    (upflow),
    .downflow  (downflow),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Latency is reported in the cycle numbering where the accepting edge
  // closes cycle k, so the first cycle showing out_valid is k + lat.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic up, input logic dn,
                         input logic dz, input int lat, input int stall);
    int edges;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, ".latency"}, 64'(edges + 1), 64'(lat));
    if (!out_valid) return;
    @(negedge clk);
    check({tag, ".out"}, 64'(out), 64'(q));
    check({tag, ".flags"}, 64'({upflow, downflow, div_zero}), 64'({up, dn, dz}));
    check({tag, ".busy_in_ready"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".stall_hold"}, 64'({out_valid, in_ready, upflow, downflow, div_zero, out}),
            64'({1'b1, 1'b0, up, dn, dz, q}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".post_hs_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".post_hs_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".post_hs_hold"}, 64'(out), 64'(q));
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.in_ready", 64'(in_ready), 64'd0);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.out", 64'(out), 64'd0);
    check("reset.flags", 64'({upflow, downflow, div_zero}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset.release_in_ready", 64'(in_ready), 64'd1);

    run_div("basic",   32'h00030000, 32'h00020000, 32'h00018000, 0, 0, 0, LAT_NORM, 0);
    run_div("neg7_2",  32'hFFF90000, 32'h00020000, 32'hFFFC8000, 0, 0, 0, LAT_NORM, 10);
    run_div("two_3",   32'h00020000, 32'h00030000, 32'h0000AAAB, 0, 0, 0, LAT_NORM, 0);
    run_div("one_3",   32'h00010000, 32'h00030000, 32'h00005555, 0, 0, 0, LAT_NORM, 0);
    run_div("ovf",     32'h7FFF0000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 0, LAT_NORM, 0);
    run_div("minneg",  32'h80000000, 32'h00010000, 32'h80000000, 0, 0, 0, LAT_NORM, 0);
    run_div("unf",     32'h00000001, 32'h7FFF0000, 32'h00000000, 0, 1, 0, LAT_NORM, 0);
    run_div("zero_n",  32'h00000000, 32'h00030000, 32'h00000000, 0, 0, 0, LAT_NORM, 0);
    run_div("dz_neg",  32'hFFFF0000, 32'h00000000, 32'h80000000, 0, 0, 1, LAT_DZ, 0);
    run_div("dz_zero", 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 1, LAT_DZ, 0);
    run_div("dz_pos",  32'h00010000, 32'h00000000, 32'h7FFFFFFF, 0, 0, 1, LAT_DZ, 0);

    // Abort a division partway through CALC.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'h00030000;
    divisor  = 32'h00020000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort.calc_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort.rst_valid", 64'(out_valid), 64'd0);
    check("abort.rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort.after_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort.no_result", 64'(seen), 64'd0);

    run_div("after_abort", 32'hFFF90000, 32'h00020000, 32'hFFFC8000, 0, 0, 0, LAT_NORM, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_fixedpoint_div.md
# seq_fixedpoint_div

Multi-cycle signed fixed-point divider. Computes `dividend / divisor` on Q(WII.WIF) two's-complement operands with one quotient bit per cycle. Produces a saturated Q(WII.WIF) quotient with overflow, underflow and divide-by-zero flags. It sits directly upstream of the fixed-point-to-float32 converter, so its `out`, `upflow` and `downflow` feed that stage's `in` and flag semantics unchanged.

## Interface
- `WII`, default 16: integer bits, sign included; must be ≥ 1.
- `WIF`, default 16: fractional bits; must be ≥ 0.
- `ROUND`, default 1: 1 = round half away from zero; 0 = truncate toward zero.
- Local `W = WII+WIF`. Local `N = WII+2*WIF+ROUND`, the iteration count.
- `clk`  in  1  clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `dividend`  in  W  signed Q(WII.WIF).
- `divisor`  in  W  signed Q(WII.WIF).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out`  out  W  signed Q(WII.WIF) quotient.
- `upflow`  out  1  result saturated.
- `downflow`  out  1  nonzero true quotient rounded/truncated to 0.
- `div_zero`  out  1  divisor was 0.

## Operation
- Four states:
  - IDLE: `in_ready`=1.
  - CALC: restoring shift-subtract over N cycles.
  - FIX: round, apply sign, saturate.
  - DONE: `out_valid`=1 until `out_ready`.
- Operand capture:
  - On `in_valid && in_ready`, register the magnitudes `|dividend| << WIF` (W+WIF bits, unsigned) and `|divisor|` (W bits), plus `sign = dividend[W-1] ^ divisor[W-1]`.
  - Magnitudes are computed one bit wider, so -2^(W-1) is handled exactly.
- CALC: produces W+WIF quotient bits, MSB first. If ROUND=1, one extra half-bit is produced.
- FIX:
  - magnitude `M` = quotient + half-bit (ROUND=1), else quotient.
  - Limit L = 2^(W-1)-1 if sign=0, else 2^(W-1).
  - If `M > L`: `out` = 0x7FF..F (positive) or 0x800..0 (negative), and `upflow`=1.
  - Otherwise `out` = sign ? -M : M.
  - `downflow` = 1 iff the dividend ≠ 0 and M = 0.
- Divisor = 0:
  - Skip CALC and go from acceptance directly to FIX.
  - `div_zero`=1, `upflow`=0, `downflow`=0.
  - `out` = 0 if dividend = 0; max positive if dividend > 0; min negative if dividend < 0.
- Dividend = 0 with nonzero divisor: `out`=0, all flags 0.

## Timing
- Reset values:
  - state IDLE.
  - `out_valid`=0, `out`=0, `upflow`=0, `downflow`=0, `div_zero`=0.
  - `in_ready`=0 while `rst` is high, then 1 from the first cycle after reset deasserts.
- Latency, with acceptance at edge k:
  - CALC occupies cycles k+1..k+N.
  - FIX occupies cycle k+N+1.
  - `out_valid` rises at cycle k+N+2 (N+2 = 51 for defaults).
  - Divide-by-zero: `out_valid` rises at k+2.
- `out`, `upflow`, `downflow` and `div_zero` are registered. They are stable for the whole time `out_valid` is high and hold their last value after the handshake.
- On `out_valid && out_ready`, the block returns to IDLE. `in_ready` is 1 on the next cycle. There is no same-cycle accept-after-complete.
- `in_ready`=0 in CALC, FIX and DONE. Operand changes are ignored there.
- `rst` asserted in any state aborts the operation on the next edge. No result is emitted.
- Throughput: one division per N+3 cycles when `out_ready` is held high.

## Structure
- `fixedpoint_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t`.
  - A width-check helper function for WII/WIF legality.
- Single module with no sub-module. The remainder/quotient shift register and iteration counter (`$clog2(N+1)` bits) are inline.

## Test plan
All vectors use defaults (WII=16, WIF=16, ROUND=1).
- **Basic:** 0x00030000 / 0x00020000 → `out`=0x00018000; all flags 0; `out_valid` exactly 51 cycles after accept.
- **Signed:** 0xFFF90000 / 0x00020000 (-7/2) → 0xFFFC8000. Also 0x00020000 / 0x00030000 → 0x0000AAAB (rounded up). Also 0x00010000 / 0x00030000 → 0x00005555.
- **Overflow:** 0x7FFF0000 / 0x00000001 → 0x7FFFFFFF with `upflow`=1. Also 0x80000000 / 0x00010000 → 0x80000000 with `upflow`=0.
- **Underflow:** 0x00000001 / 0x7FFF0000 → `out`=0, `downflow`=1.
- **Divide by zero:** 0xFFFF0000 / 0 → 0x80000000, `div_zero`=1, `out_valid` at k+2. Also 0 / 0 → 0, `div_zero`=1.
- **Handshake/reset:**
  - Hold `out_ready`=0 for 10 cycles: outputs stay stable and `in_ready`=0.
  - Assert `rst` mid-CALC: `out_valid` stays 0, and `in_ready`=1 the cycle after `rst` drops.
  - Then a new division completes correctly.
